uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter Data_length, default 8, SHALL set the payload width per requester.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (legal range 2..8).
REQ-003 Parameter TIMEOUT_CYC, default 4096, SHALL set the transfer watchdog limit in clk2 cycles.
REQ-004 clk2  input  1  SHALL be the single clock; all logic is on posedge clk2.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  SHALL carry per-requester transmit requests, level-sensitive.
REQ-007 req_data  input  NUM_REQ*Data_length  SHALL carry the payloads; requester i occupies bits [i*Data_length +: Data_length].
REQ-008 tx_done  input  1  SHALL be the transmitter status: high when idle, low while a frame is in flight.
REQ-009 grant  output  NUM_REQ  SHALL be a one-hot (or zero) owner indication.
REQ-010 ack  output  NUM_REQ  SHALL be a one-cycle per-requester completion pulse.
REQ-011 tx_start  output  1  SHALL be a one-cycle launch pulse to the transmitter.
REQ-012 tx_data  output  Data_length  SHALL carry the latched payload of the granted requester.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 timeout_err  output  1  SHALL be a one-cycle watchdog-expiry pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH and DONE, all registered.
REQ-016 IDLE SHALL move to LAUNCH only when |req=1 and tx_done=1; otherwise it SHALL stay in IDLE.
REQ-017 Winner selection SHALL be round-robin: the search starts at index (last_grant+1) mod NUM_REQ and the first asserted req wins.
REQ-018 On the IDLE->LAUNCH edge, grant, tx_data and last_grant SHALL be registered, so they are valid in the first LAUNCH cycle (latency 1 cycle from req sampled).
REQ-019 tx_start SHALL be high for exactly the single LAUNCH cycle; LAUNCH SHALL always move to WAIT_LOW.
REQ-020 WAIT_LOW SHALL move to WAIT_HIGH when tx_done=0; WAIT_HIGH SHALL move to DONE when tx_done=1.
REQ-021 In DONE, ack[winner] SHALL pulse for one cycle, grant SHALL clear at the end of that cycle, and the FSM SHALL return to IDLE.
REQ-022 tx_data and grant SHALL remain stable from LAUNCH through DONE, regardless of req or req_data changes.
REQ-023 If a requester drops req after grant, its transfer SHALL still complete and ack SHALL still pulse.
REQ-024 A requester that holds req continuously SHALL be re-arbitrated, and any other pending requester SHALL win before it is served again.
REQ-025 With all req high, grants SHALL rotate 0,1,...,NUM_REQ-1,0 after reset.
REQ-026 The minimum spacing between consecutive tx_start pulses SHALL be 4 cycles plus the transmitter's tx_done low time.
REQ-027 req bits at or above NUM_REQ do not exist; an all-zero req SHALL never produce a grant.

Reset
REQ-028 While rst=1 at a clk2 edge, the outputs SHALL take these values: state=IDLE, grant=0, ack=0, tx_start=0, tx_data=0, busy=0, timeout_err=0, last_grant=NUM_REQ-1, watchdog=0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no ack, and requester 0 SHALL have top priority afterwards.

Configuration
REQ-030 With macro UART_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WAIT_LOW and WAIT_HIGH and clear on entry to LAUNCH.
REQ-031 With UART_ARB_TIMEOUT_EN defined, a watchdog reaching TIMEOUT_CYC-1 SHALL pulse timeout_err for one cycle, clear grant, suppress ack, keep last_grant advanced and go to IDLE.
REQ-032 Without UART_ARB_TIMEOUT_EN, no watchdog SHALL be built, timeout_err SHALL be tied 0, TIMEOUT_CYC SHALL be ignored, and the wait states SHALL wait indefinitely.

Verification
REQ-033 Reset, then req=4'b0001 with data 8'hA5 and tx_done low 10 cycles after tx_start -> grant=0001 and tx_data=A5 in the cycle after req; one tx_start; ack[0] pulses once; busy then falls.
REQ-034 req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3 and exactly 8 acks.
REQ-035 req=4'b0101 with requester 2 dropping req in WAIT_HIGH -> transfer completes, ack[2] pulses, and the next grant goes to requester 0.
REQ-036 tx_done held low in IDLE with req=4'b0010 -> no grant and no tx_start until tx_done=1, then grant=0010 on the following cycle.
REQ-037 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, tx_done never falls after tx_start -> timeout_err pulses 16 cycles after WAIT_LOW entry, no ack, FSM returns to IDLE.
REQ-038 rst pulsed during WAIT_HIGH of requester 3 -> all outputs at reset values the next cycle, no ack[3], and the next grant with req=4'b1001 goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the wait-state watchdog (timeout_err, TIMEOUT_CYC).
module uart_tx_arbiter #(
  parameter int Data_length = 8,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           clk2,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*Data_length-1:0] req_data,
  input  logic                           tx_done,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx_start,
  output logic [Data_length-1:0]         tx_data,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                 state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic                   tx_start_q;
  logic [Data_length-1:0] tx_data_q;
  logic                   busy_q;
  logic [IDX_W-1:0]       last_grant_q;

  logic [Data_length-1:0] req_data_arr [NUM_REQ];
  logic [IDX_W-1:0]       winner_d;
  logic                   winner_vld_d;
  int unsigned            rr_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*Data_length +: Data_length];
    end
  endgenerate

  // Walk from the farthest candidate toward the nearest so the nearest asserted
  // requester after last_grant overwrites all others.
  always_comb begin
    winner_d     = '0;
    winner_vld_d = 1'b0;
    rr_sum       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = int'(unsigned'(last_grant_q)) + 1 + k;
      if (rr_sum >= NUM_REQ) begin
        rr_sum = rr_sum - NUM_REQ;
      end
      if (req[IDX_W'(rr_sum)]) begin
        winner_d     = IDX_W'(rr_sum);
        winner_vld_d = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (winner_vld_d && tx_done) begin
            state_q      <= LAUNCH;
            grant_q      <= NUM_REQ'(1) << winner_d;
            tx_data_q    <= req_data_arr[winner_d];
            last_grant_q <= winner_d;
            tx_start_q   <= 1'b1;
            busy_q       <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            wd_q         <= '0;
`endif
          end
        end

        LAUNCH: begin
          state_q <= WAIT_LOW;
        end

        WAIT_LOW: begin
`ifdef UART_ARB_TIMEOUT_EN
          wd_q <= wd_q + 1'b1;
          if (wd_expired) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (!tx_done) begin
            state_q <= WAIT_HIGH;
          end
`else
          if (!tx_done) begin
            state_q <= WAIT_HIGH;
          end
`endif
        end

        WAIT_HIGH: begin
`ifdef UART_ARB_TIMEOUT_EN
          wd_q <= wd_q + 1'b1;
          if (wd_expired) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (tx_done) begin
            state_q <= DONE;
            ack_q   <= grant_q;
          end
`else
          if (tx_done) begin
            state_q <= DONE;
            ack_q   <= grant_q;
          end
`endif
        end

        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  // The watchdog limit has no meaning without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_err        = 1'b0;
`endif

endmodule
